// File: rtl/asip_vec_pkg.sv
// Shared types for the vector ASIP execute-stage completion logic.
package asip_vec_pkg;

    typedef enum logic [1:0] {
        OP_SCALAR = 2'd0,
        OP_VECTOR = 2'd1,
        OP_REDUCE = 2'd2
    } op_type_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TAIL,
        DONE
    } vec_op_state_e;

    localparam int unsigned LANES_DEF = 4;
    localparam int unsigned TAIL_W    = $clog2(LANES_DEF);

    // Number of reduction-tree drain cycles for a given lane count.
    function automatic int unsigned tail_w(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// Combinational per-lane valid mask for the current beat of a vector operation.
module lane_mask_gen
    import asip_vec_pkg::*;
#(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned LANES = 4
) (
    input  logic             en,
    input  op_type_e         mode,
    input  logic [CNT_W-1:0] elem_idx,
    input  logic [CNT_W-1:0] vector_max,
    output logic [LANES-1:0] lane_valid
);

    always_comb begin
        lane_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            if (en) begin
                if (mode == OP_SCALAR) begin
                    lane_valid[i] = (i == 0);
                end else begin
                    // One extra bit so lanes past 2^CNT_W-1 never wrap back to valid.
                    lane_valid[i] = ({1'b0, elem_idx} + (CNT_W + 1)'(i)) <= {1'b0, vector_max};
                end
            end
        end
    end

endmodule

// File: rtl/vec_op_completion.sv
// Completion controller: element counter, lane masking, reduction tail and finished/done flags.
// Optional cycle counter output op_cycles when VEC_OP_COMPLETION_PERF_EN is defined.
module vec_op_completion
    import asip_vec_pkg::*;
#(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned LANES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_type,
    input  logic [CNT_W-1:0] vector_max,
    input  logic             stall,
`ifdef VEC_OP_COMPLETION_PERF_EN
    output logic [15:0]      op_cycles,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] elem_idx,
    output logic [LANES-1:0] lane_valid,
    output logic             finished,
    output logic             done_pulse
);

    localparam int unsigned TAIL_LEN = tail_w(LANES);
    localparam int unsigned TCNT_W   = (TAIL_LEN > 0) ? TAIL_LEN : 1;
    localparam logic [TCNT_W-1:0] TAIL_LAST = TCNT_W'((TAIL_LEN > 0) ? TAIL_LEN - 1 : 0);

    vec_op_state_e    state_q, state_d;
    op_type_e         op_q, op_d;
    logic [CNT_W-1:0] vmax_q, vmax_d;
    logic [CNT_W-1:0] elem_idx_q, elem_idx_d;
    logic [TCNT_W-1:0] tail_q, tail_d;
    logic             done_pulse_q, done_pulse_d;
    logic             accept;
    logic             last_beat;
    logic [CNT_W:0]   next_sum;

    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign next_sum = {1'b0, elem_idx_q} + (CNT_W + 1)'(LANES);
    assign last_beat = (op_q == OP_SCALAR) || (next_sum > {1'b0, vmax_q});

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        vmax_d     = vmax_q;
        elem_idx_d = elem_idx_q;
        tail_d     = tail_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    vmax_d     = vector_max;
                    elem_idx_d = '0;
                    tail_d     = '0;
                    case (op_type)
                        2'd1:    op_d = OP_VECTOR;
                        2'd2:    op_d = OP_REDUCE;
                        default: op_d = OP_SCALAR;
                    endcase
                end
            end
            RUN: begin
                if (!stall) begin
                    if (last_beat) begin
                        tail_d  = '0;
                        state_d = (op_q == OP_REDUCE && TAIL_LEN > 0) ? TAIL : DONE;
                    end else begin
                        elem_idx_d = elem_idx_q + CNT_W'(LANES);
                    end
                end
            end
            TAIL: begin
                if (!stall) begin
                    if (tail_q == TAIL_LAST) begin
                        state_d = DONE;
                    end else begin
                        tail_d = tail_q + TCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        done_pulse_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_SCALAR;
            vmax_q       <= '0;
            elem_idx_q   <= '0;
            tail_q       <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            vmax_q       <= vmax_d;
            elem_idx_q   <= elem_idx_d;
            tail_q       <= tail_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == TAIL);
    assign finished   = (state_q == DONE);
    assign done_pulse = done_pulse_q;
    assign elem_idx   = elem_idx_q;

    lane_mask_gen #(
        .CNT_W (CNT_W),
        .LANES (LANES)
    ) u_lane_mask_gen (
        .en         (state_q == RUN),
        .mode       (op_q),
        .elem_idx   (elem_idx_q),
        .vector_max (vmax_q),
        .lane_valid (lane_valid)
    );

`ifdef VEC_OP_COMPLETION_PERF_EN
    logic [15:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (accept) begin
            cycles_d = '0;
        end else if (busy && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign op_cycles = cycles_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
